// File: rtl/divider64_pkg.sv
// divider64_pkg: shared constants for the iterative 64-bit divider.
//   state_e     : FSM encoding (IDLE, PREP, DIV, FIX, DONE), 3 bits
//   DIV_WIDTH   : operand width
//   DIV_ITERS   : quotient bits produced, one per DIV cycle
//   DIV_LATENCY : cycles from the accepting edge to the done edge
package divider64_pkg;

  localparam int DIV_WIDTH   = 64;
  localparam int DIV_ITERS   = 64;
  localparam int DIV_LATENCY = 67;
  localparam int DIV_CNT_W   = $clog2(DIV_ITERS);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/divider64_adder64.sv
// adder64: plain 64-bit adder with carry in/out. The divider uses it as a
// subtractor by feeding ~b and cin=1.
//   a, b : operands
//   cin  : carry in
//   sum  : a + b + cin (low WIDTH bits)
//   cout : carry out
module adder64
  import divider64_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/divider64.sv
// divider64: iterative restoring divider, one quotient bit per clock.
// Signed (truncating) or unsigned; fixed 67-cycle latency via start/done.
//   clk, rst_n          : clock, synchronous active-low reset
//   start, is_signed    : request + mode, sampled in IDLE only
//   dividend, divisor   : operands, sampled with start
//   busy                : high from PREP through DONE
//   done                : one-cycle result-valid pulse
//   quotient, remainder : registered results, held until next operation
//   div_by_zero         : registered flag, held like the results
module divider64
  import divider64_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [WIDTH-1:0]     ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(DIV_ITERS - 1);

  state_e state, state_nxt;

  // latched request
  logic             req_signed;
  logic [WIDTH-1:0] req_dd, req_dv;

  // working registers
  logic [WIDTH-1:0]     rem, q, abs_dv;
  logic [DIV_CNT_W-1:0] cnt;
  logic                 q_neg, r_neg, zero;

  // operand magnitudes, only consumed in PREP
  logic             dd_neg, dv_neg;
  logic [WIDTH-1:0] abs_dd_c, abs_dv_c;

  assign dd_neg   = req_signed & req_dd[WIDTH-1];
  assign dv_neg   = req_signed & req_dv[WIDTH-1];
  assign abs_dd_c = dd_neg ? (~req_dd + ONE) : req_dd;
  assign abs_dv_c = dv_neg ? (~req_dv + ONE) : req_dv;

  // trial subtraction: shifted_rem - abs_dv
  logic [WIDTH-1:0] sh_rem, diff;
  logic             rem_msb_out, cout, take;

  assign sh_rem      = {rem[WIDTH-2:0], q[WIDTH-1]};
  assign rem_msb_out = rem[WIDTH-1];

  adder64 #(.WIDTH(WIDTH)) u_sub (
    .a    (sh_rem),
    .b    (~abs_dv),
    .cin  (1'b1),
    .sum  (diff),
    .cout (cout)
  );

  // the bit shifted out of rem makes the true partial remainder WIDTH+1
  // bits wide, so it always exceeds the divisor
  assign take = rem_msb_out | cout;

  // FSM
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = PREP;
      end
      PREP:    state_nxt = DIV;
      DIV:     if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_signed  <= 1'b0;
      req_dd      <= '0;
      req_dv      <= '0;
      rem         <= '0;
      q           <= '0;
      abs_dv      <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      zero        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          req_signed <= is_signed;
          req_dd     <= dividend;
          req_dv     <= divisor;
        end
        PREP: begin
          rem    <= '0;
          q      <= abs_dd_c;
          abs_dv <= abs_dv_c;
          q_neg  <= dd_neg ^ dv_neg;
          r_neg  <= dd_neg;
          zero   <= (req_dv == '0);
          cnt    <= CNT_LAST;
        end
        DIV: begin
          rem <= take ? diff : sh_rem;
          q   <= {q[WIDTH-2:0], take};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          // sign fix-up is registered here, off the adder path
          if (zero) begin
            quotient    <= '1;
            remainder   <= req_dd;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q_neg ? (~q + ONE) : q;
            remainder   <= r_neg ? (~rem + ONE) : rem;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
